// File: rtl/lbist_session_ctrl.sv
// rtl/lbist_session_ctrl.sv - logic-BIST session sequencer (optional macro LBIST_SIG_CAPTURE_EN adds sig_o)
module lbist_session_ctrl #(
   parameter int unsigned            SCAN_LEN   = 64,
   parameter int unsigned            N_PATTERNS = 1024,
   parameter int unsigned            MISR_WIDTH = 32,
   parameter logic [MISR_WIDTH-1:0]  GOLDEN_SIG = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              start_i,
   input  logic [MISR_WIDTH-1:0]             misr_sig_i,
   output logic                              test_mode_o,
   output logic                              scan_en_o,
   output logic                              prpg_seed_o,
   output logic                              prpg_en_o,
   output logic                              misr_clr_o,
   output logic                              misr_en_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              go_nogo_o,
   output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt_o
`ifdef LBIST_SIG_CAPTURE_EN
   ,
   output logic [MISR_WIDTH-1:0]             sig_o
`endif
);

   localparam int unsigned SC_W = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
   localparam int unsigned PC_W = $clog2(N_PATTERNS + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_LEN - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(N_PATTERNS - 1);
   localparam logic [PC_W-1:0] PC_MAX  = PC_W'(N_PATTERNS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SHIFT,
      ST_CAPTURE,
      ST_UNLOAD,
      ST_COMPARE,
      ST_DONE
   } state_t;

   state_t          state;
   logic [SC_W-1:0] shift_cnt;

   // Session FSM; every output is loaded together with the state it belongs to
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= ST_IDLE;
         shift_cnt     <= '0;
         pattern_cnt_o <= '0;
         test_mode_o   <= 1'b0;
         scan_en_o     <= 1'b0;
         prpg_seed_o   <= 1'b0;
         prpg_en_o     <= 1'b0;
         misr_clr_o    <= 1'b0;
         misr_en_o     <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         go_nogo_o     <= 1'b0;
      end else begin
         // seed and clear only ever last the single INIT cycle
         prpg_seed_o <= 1'b0;
         misr_clr_o  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state         <= ST_INIT;
                  test_mode_o   <= 1'b1;
                  busy_o        <= 1'b1;
                  prpg_seed_o   <= 1'b1;
                  misr_clr_o    <= 1'b1;
                  shift_cnt     <= '0;
                  pattern_cnt_o <= '0;
               end
            end
            ST_INIT: begin
               // first shift pass unloads uninitialised flops, so the MISR stays off
               state     <= ST_SHIFT;
               scan_en_o <= 1'b1;
               prpg_en_o <= 1'b1;
               misr_en_o <= 1'b0;
            end
            ST_SHIFT: begin
               if (shift_cnt == SC_LAST) begin
                  state     <= ST_CAPTURE;
                  shift_cnt <= '0;
                  scan_en_o <= 1'b0;
                  prpg_en_o <= 1'b0;
                  misr_en_o <= 1'b0;
               end else begin
                  shift_cnt <= shift_cnt + 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (pattern_cnt_o != PC_MAX) begin
                  pattern_cnt_o <= pattern_cnt_o + 1'b1;
               end
               scan_en_o <= 1'b1;
               misr_en_o <= 1'b1;
               if (pattern_cnt_o >= PC_LAST) begin
                  state     <= ST_UNLOAD;
                  prpg_en_o <= 1'b0;
               end else begin
                  state     <= ST_SHIFT;
                  prpg_en_o <= 1'b1;
               end
            end
            ST_UNLOAD: begin
               if (shift_cnt == SC_LAST) begin
                  state     <= ST_COMPARE;
                  shift_cnt <= '0;
                  scan_en_o <= 1'b0;
                  misr_en_o <= 1'b0;
               end else begin
                  shift_cnt <= shift_cnt + 1'b1;
               end
            end
            ST_COMPARE: begin
               state     <= ST_DONE;
               go_nogo_o <= (misr_sig_i == GOLDEN_SIG);
               busy_o    <= 1'b0;
               done_o    <= 1'b1;
            end
            ST_DONE: begin
               // a held start_i keeps the result visible; a new session needs a fresh rise
               if (!start_i) begin
                  state         <= ST_IDLE;
                  test_mode_o   <= 1'b0;
                  done_o        <= 1'b0;
                  go_nogo_o     <= 1'b0;
                  pattern_cnt_o <= '0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               test_mode_o <= 1'b0;
               scan_en_o   <= 1'b0;
               prpg_en_o   <= 1'b0;
               misr_en_o   <= 1'b0;
               busy_o      <= 1'b0;
               done_o      <= 1'b0;
            end
         endcase
      end
   end

`ifdef LBIST_SIG_CAPTURE_EN
   // Snapshot of the final signature for debug, held through DONE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sig_o <= '0;
      end else if (state == ST_COMPARE) begin
         sig_o <= misr_sig_i;
      end else if (state == ST_DONE && !start_i) begin
         sig_o <= '0;
      end
   end
`endif

endmodule
